pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RV32 core fetch stage and successor to the fixed 10-bit PC. It holds the fetch address and advances it by 4 or redirects it through one of five modes: sequential, conditional branch, JAL, JALR or return. It adds fetch stall, a return-address stack (RAS) for call/return prediction, and an instruction-address-misaligned trap with exception PC capture. It feeds the instruction memory address and the writeback link value.

## Interface

- ADDR_WIDTH, 10, width of the PC and all address ports; arithmetic wraps modulo 2^ADDR_WIDTH.
- OFFSET_WIDTH, 20, width of the signed byte offset input.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).
- RESET_VECTOR, 0, PC value after reset.
- TRAP_VECTOR, 256, PC loaded on a misaligned target.

Ports:

- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low.
- stall  in  1  1 = hold all state this cycle.
- mode  in  3  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR, 4 RET; codes 5–7 behave as SEQ.
- taken  in  1  branch condition; used only in BRANCH mode.
- offset  in  OFFSET_WIDTH  signed byte offset, sign-extended or truncated to ADDR_WIDTH.
- base  in  ADDR_WIDTH  rs1 value for JALR.
- pc_out  out  ADDR_WIDTH  current fetch PC (registered).
- link_out  out  ADDR_WIDTH  pc_out+4 (combinational, wraps).
- misalign  out  1  registered one-cycle trap pulse.
- epc  out  ADDR_WIDTH  PC of the faulting instruction (registered).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

## Operation

- Next-target selection (ext = offset sign-extended/truncated to ADDR_WIDTH):
  - SEQ: pc+4.
  - BRANCH: taken ? pc+ext : pc+4.
  - JAL: pc+ext.
  - JALR: (base+ext) with bit 0 cleared.
  - RET: top of RAS; if RAS empty, pc+4.
- All sums are truncated to ADDR_WIDTH; no carry out.
- Misalign check: the target is misaligned when target[1:0] ≠ 0. Only redirecting targets are checked (taken BRANCH, JAL, JALR, non-empty RET).
- On a misaligned target:
  - pc_out ← TRAP_VECTOR, epc ← pc_out, misalign ← 1.
  - No RAS push or pop.
- RAS push: a JAL with an aligned target pushes pc+4.
  - When full, the push overwrites the oldest entry (circular); the count stays at RAS_DEPTH and ras_full stays 1.
- RAS pop: a RET with a non-empty RAS pops one entry; the count decrements.
- RAS on RET with empty stack: falls through to pc+4; no pop; no error.
- Stall: pc_out, epc, RAS contents and count are held, and mode is ignored. misalign is driven to 0 during a stall.
- Priority: reset > stall > mode.

## Timing

- All state updates on the rising edge of clk; the new pc_out is visible one cycle after mode is applied (redirect latency 1).
- Values while reset=0 at an edge:
  - pc_out = RESET_VECTOR, epc = 0, misalign = 0.
  - RAS count = 0 (ras_empty=1, ras_full=0).
  - RAS entry contents are don't-care.
- Reset asserted mid-operation (stalled, or in the cycle after a trap) takes effect at the next edge regardless of other inputs.
- misalign is high for exactly the one cycle in which pc_out first equals TRAP_VECTOR, then returns to 0 unless a new trap occurs.
- link_out follows pc_out combinationally in the same cycle.
- ras_empty and ras_full are derived from the registered count and change only on edges.

## Test plan

- Reset then SEQ (defaults): reset low for 1 edge → pc_out=0, ras_empty=1; 2 SEQ edges → pc_out=4, then 8; link_out=12.
- BRANCH:
  - from 8, taken=1, offset=196 → pc_out=204.
  - taken=1, offset=800 → pc_out=1004 (0x3EC).
  - taken=0 → pc_out=1008.
- Wrap: from pc 1020, SEQ → pc_out=0; offset=-8 from 0 → pc_out=1016.
- Misaligned target:
  - at pc 16, JAL offset=6 → pc_out=256, epc=16, misalign=1 for one cycle, RAS unchanged.
  - JALR base=33, offset=0 → target 32, aligned, no trap.
- RAS:
  - Call/return: at pc 16, JAL offset=100 → pc_out=116 with 20 pushed; RET → pc_out=20, ras_empty=1.
  - Overflow: from pc 0, five JALs of +64 → ras_full=1. Then five RETs → pops return 260, 196, 132, 68 (the entry 4 was overwritten), then the fifth RET falls through to pc+4.
- Stall and reset interaction:
  - stall=1 with mode=JAL for 3 cycles → pc_out, RAS and epc unchanged, misalign=0.
  - reset low while stall=1 → pc_out=0 at the next edge.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : RV32 fetch program counter with branch/jump redirect,
//               return-address stack and misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int ADDR_WIDTH   = 10,
    parameter int OFFSET_WIDTH = 20,
    parameter int RAS_DEPTH    = 4,
    parameter int RESET_VECTOR = 0,
    parameter int TRAP_VECTOR  = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [2:0]              mode,
    input  logic                    taken,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [ADDR_WIDTH-1:0]   base,
    output logic [ADDR_WIDTH-1:0]   pc_out,
    output logic [ADDR_WIDTH-1:0]   link_out,
    output logic                    misalign,
    output logic [ADDR_WIDTH-1:0]   epc,
    output logic                    ras_empty,
    output logic                    ras_full
);

    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [2:0] c_MODE_SEQ    = 3'd0;
    localparam logic [2:0] c_MODE_BRANCH = 3'd1;
    localparam logic [2:0] c_MODE_JAL    = 3'd2;
    localparam logic [2:0] c_MODE_JALR   = 3'd3;
    localparam logic [2:0] c_MODE_RET    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_FOUR      = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_RESET_PC  = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] c_TRAP_PC   = ADDR_WIDTH'(TRAP_VECTOR);
    localparam logic [c_CNT_W-1:0]    c_DEPTH_CNT = c_CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic                  r_misalign;
    logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [ADDR_WIDTH-1:0] w_ext;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_pc_rel;
    logic [ADDR_WIDTH-1:0] w_jalr_sum;
    logic [ADDR_WIDTH-1:0] w_ras_top;
    logic [c_PTR_W-1:0]    w_ptr_dec;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_redirect;
    logic                  w_is_jal;
    logic                  w_is_pop;
    logic                  w_misalign;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ras_empty;

    // Offset is sign-extended when narrower than the PC, truncated otherwise.
    generate
        if (OFFSET_WIDTH >= ADDR_WIDTH) begin : g_ext_trunc
            assign w_ext = offset[ADDR_WIDTH-1:0];
            if (OFFSET_WIDTH > ADDR_WIDTH) begin : g_ext_unused
                logic w_unused_ofs;
                assign w_unused_ofs = ^offset[OFFSET_WIDTH-1:ADDR_WIDTH];
            end
        end else begin : g_ext_sext
            assign w_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
        end
    endgenerate

    assign w_pc_plus4  = r_pc + c_FOUR;
    assign w_pc_rel    = r_pc + w_ext;
    assign w_jalr_sum  = base + w_ext;
    assign w_ptr_dec   = r_ptr - 1'b1;
    assign w_ras_top   = r_ras[w_ptr_dec];
    assign w_ras_empty = (r_cnt == '0);

    always_comb begin
        w_target   = w_pc_plus4;
        w_redirect = 1'b0;
        w_is_jal   = 1'b0;
        w_is_pop   = 1'b0;
        case (mode)
            c_MODE_SEQ: begin
                w_target = w_pc_plus4;
            end
            c_MODE_BRANCH: begin
                if (taken) begin
                    w_target   = w_pc_rel;
                    w_redirect = 1'b1;
                end
            end
            c_MODE_JAL: begin
                w_target   = w_pc_rel;
                w_redirect = 1'b1;
                w_is_jal   = 1'b1;
            end
            c_MODE_JALR: begin
                w_target   = {w_jalr_sum[ADDR_WIDTH-1:1], 1'b0};
                w_redirect = 1'b1;
            end
            c_MODE_RET: begin
                // An empty stack quietly falls through to the next instruction.
                if (!w_ras_empty) begin
                    w_target   = w_ras_top;
                    w_redirect = 1'b1;
                    w_is_pop   = 1'b1;
                end
            end
            default: begin
                w_target = w_pc_plus4;
            end
        endcase
    end

    assign w_misalign = w_redirect && (w_target[1:0] != 2'b00);
    assign w_push     = w_is_jal && !w_misalign;
    assign w_pop      = w_is_pop && !w_misalign;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= c_RESET_PC;
            r_epc      <= '0;
            r_misalign <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else if (stall) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            if (w_misalign) begin
                r_pc  <= c_TRAP_PC;
                r_epc <= r_pc;
            end else begin
                r_pc <= w_target;
            end
            // A push on a full stack overwrites the oldest slot, count saturates.
            if (w_push) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_cnt != c_DEPTH_CNT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_ptr <= w_ptr_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !stall && w_push) begin
            r_ras[r_ptr] <= w_pc_plus4;
        end
    end

    assign pc_out    = r_pc;
    assign link_out  = w_pc_plus4;
    assign misalign  = r_misalign;
    assign epc       = r_epc;
    assign ras_empty = w_ras_empty;
    assign ras_full  = (r_cnt == c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Scoreboard bench for pc_unit against a queue-based PC/RAS model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int c_AW    = 10;
    localparam int c_OW    = 20;
    localparam int c_DEPTH = 4;
    localparam int c_RV    = 0;
    localparam int c_TV    = 256;
    localparam int c_MASK  = (1 << c_AW) - 1;

    typedef struct {
        int pc;
        int epc;
        int link;
        int mis;
        int empty;
        int full;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic [2:0]        mode = 3'd0;
    logic              taken = 1'b0;
    logic [c_OW-1:0]   offset = '0;
    logic [c_AW-1:0]   base = '0;
    logic [c_AW-1:0]   pc_out;
    logic [c_AW-1:0]   link_out;
    logic              misalign;
    logic [c_AW-1:0]   epc;
    logic              ras_empty;
    logic              ras_full;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    int m_pc = 0;
    int m_epc = 0;
    int m_mis = 0;
    int m_ras[$];

    pc_unit #(
        .ADDR_WIDTH  (c_AW),
        .OFFSET_WIDTH(c_OW),
        .RAS_DEPTH   (c_DEPTH),
        .RESET_VECTOR(c_RV),
        .TRAP_VECTOR (c_TV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .mode     (mode),
        .taken    (taken),
        .offset   (offset),
        .base     (base),
        .pc_out   (pc_out),
        .link_out (link_out),
        .misalign (misalign),
        .epc      (epc),
        .ras_empty(ras_empty),
        .ras_full (ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, expv, $time);
        end
    endtask

    // Architectural model: PC as an integer modulo 2^AW, RAS as a bounded queue.
    task automatic model(input bit rn, input bit st, input int md, input bit tk,
                         input int off, input int bs);
        int tgt;
        bit redir;
        bit bad;
        if (!rn) begin
            m_pc  = c_RV;
            m_epc = 0;
            m_mis = 0;
            m_ras.delete();
        end else if (st) begin
            m_mis = 0;
        end else begin
            tgt   = (m_pc + 4) & c_MASK;
            redir = 1'b0;
            case (md)
                1: if (tk) begin tgt = (m_pc + off) & c_MASK; redir = 1'b1; end
                2: begin tgt = (m_pc + off) & c_MASK; redir = 1'b1; end
                3: begin tgt = ((bs + off) & c_MASK) & ~1; redir = 1'b1; end
                4: if (m_ras.size() > 0) begin tgt = m_ras[$]; redir = 1'b1; end
                default: ;
            endcase
            bad   = redir && ((tgt % 4) != 0);
            m_mis = bad ? 1 : 0;
            if (bad) begin
                m_epc = m_pc;
                m_pc  = c_TV;
            end else begin
                if (md == 2) begin
                    m_ras.push_back((m_pc + 4) & c_MASK);
                    if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
                end else if (md == 4 && redir) begin
                    void'(m_ras.pop_back());
                end
                m_pc = tgt;
            end
        end
    endtask

    task automatic step(input bit rn, input bit st, input int md, input bit tk,
                        input int off, input int bs);
        exp_t e;
        @(negedge clk);
        reset  = rn;
        stall  = st;
        mode   = md[2:0];
        taken  = tk;
        offset = off[c_OW-1:0];
        base   = bs[c_AW-1:0];
        model(rn, st, md, tk, off, bs);
        e.pc    = m_pc;
        e.epc   = m_epc;
        e.link  = (m_pc + 4) & c_MASK;
        e.mis   = m_mis;
        e.empty = (m_ras.size() == 0) ? 1 : 0;
        e.full  = (m_ras.size() == c_DEPTH) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_out",    int'(pc_out),    e.pc);
                chk("link_out",  int'(link_out),  e.link);
                chk("epc",       int'(epc),       e.epc);
                chk("misalign",  int'(misalign),  e.mis);
                chk("ras_empty", int'(ras_empty), e.empty);
                chk("ras_full",  int'(ras_full),  e.full);
            end
        end
    end

    initial begin : driver
        int md;
        int off;
        // Reset then sequential fetch
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Branches
        step(1, 0, 1, 1, 196, 0);
        step(1, 0, 1, 1, 800, 0);
        step(1, 0, 1, 0, 800, 0);
        // Wrap-around both directions
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, -8, 0);
        // Misaligned JAL trap, then aligned JALR with odd base
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 0, 6, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 33);
        // Call / return
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 0, 100, 0);
        step(1, 0, 4, 0, 0, 0);
        // RAS overflow and drain past empty
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 2, 0, 64, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 4, 0, 0, 0);
        // Stall with pending JAL, then reset during stall
        step(1, 0, 2, 0, 64, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 6, 0);
        step(0, 1, 2, 0, 6, 0);
        // Trap followed immediately by reset
        step(1, 0, 2, 0, 2, 0);
        step(0, 0, 2, 0, 2, 0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            md  = $urandom_range(0, 7);
            off = int'($urandom_range(0, 63)) * 4 - 128;
            if ($urandom_range(0, 7) == 0) off = off + int'($urandom_range(1, 3));
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0), md,
                 $urandom_range(0, 1), off, $urandom_range(0, c_MASK));
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
